// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and helpers for the round controller
package game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam int MAX_TARGETS = 32;
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int popcount(input logic [MAX_TARGETS-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_TARGETS; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/fall_edge_detect.sv
// fall_edge_detect: registered previous value and prev & ~cur falling-edge pulses
module fall_edge_detect #(
  parameter int W = 1
) (
  input  logic         vga_clk,
  input  logic         reset,
  input  logic [W-1:0] cur,
  output logic [W-1:0] fall
);
  logic [W-1:0] prev;
  always_ff @(posedge vga_clk)
    if (reset) prev <= '0;
    else prev <= cur;
  assign fall = prev & ~cur;
endmodule

// File: rtl/game_round_controller.sv
// game_round_controller: round timer, ammo, hit scoring and game state machine
module game_round_controller
  import game_pkg::*;
#(
  parameter int NUM_TARGETS   = 4,
  parameter int MAG_DEPTH     = 4,
  parameter int SCORE_W       = 8,
  parameter int TICKS_PER_SEC = 24000000,
  parameter int ROUND_SECS    = 30,
  parameter int AUTO_START    = 1,
  localparam int AMMO_W = bits_for(MAG_DEPTH + 1),
  localparam int SECS_W = bits_for(ROUND_SECS + 1),
  localparam int PRE_W  = bits_for(TICKS_PER_SEC)
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   fire,
  input  logic                   reload,
  input  logic [NUM_TARGETS-1:0] hit,
  output logic                   fire_ok,
  output logic                   run,
  output logic [AMMO_W-1:0]      ammo,
  output logic [SCORE_W-1:0]     score,
  output logic [SECS_W-1:0]      secs,
  output logic [NUM_TARGETS-1:0] target_hit,
  output logic [1:0]             state,
  output logic                   round_over
);
  localparam int SMAX = (1 << SCORE_W) - 1;
  state_t st;
  logic [PRE_W-1:0] presc;
  logic shot;
  logic [NUM_TARGETS-1:0] hit_ev;
  logic play, tick, expire, restart;
  int sum;
  fall_edge_detect #(.W(1)) u_fire (.vga_clk(vga_clk), .reset(reset), .cur(fire), .fall(shot));
  fall_edge_detect #(.W(NUM_TARGETS)) u_hit (.vga_clk(vga_clk), .reset(reset), .cur(hit), .fall(hit_ev));
  assign play    = st == PLAY;
  assign tick    = play && presc == PRE_W'(TICKS_PER_SEC - 1);
  assign expire  = tick && secs == SECS_W'(ROUND_SECS - 1);
  assign restart = !play && start;
  assign sum     = int'(score) + popcount(MAX_TARGETS'(hit_ev));
  assign state   = st;
  assign run     = play;
  assign fire_ok = fire && play && ammo != '0;
  always_ff @(posedge vga_clk)
    if (reset) begin
      st         <= (AUTO_START != 0) ? PLAY : IDLE;
      round_over <= 1'b0;
    end else begin
      st         <= restart ? PLAY : expire ? OVER : st;
      round_over <= expire;
    end
  always_ff @(posedge vga_clk)
    if (reset) begin
      presc      <= '0;
      secs       <= '0;
      ammo       <= AMMO_W'(MAG_DEPTH);
      score      <= '0;
      target_hit <= '0;
    end else begin
      target_hit <= play ? hit_ev : '0;
      if (restart) begin
        presc <= '0;
        secs  <= '0;
        ammo  <= AMMO_W'(MAG_DEPTH);
        score <= '0;
      end else if (play) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        secs  <= secs + SECS_W'(tick);
        ammo  <= reload ? AMMO_W'(MAG_DEPTH) : ammo - AMMO_W'(shot && ammo != '0);
        score <= (sum > SMAX) ? SCORE_W'(SMAX) : SCORE_W'(sum);
      end
    end
endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed checks of timer, ammo, scoring and restart
module tb_game_round_controller;
  import game_pkg::*;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, fire = 1'b0, reload = 1'b0, start2 = 1'b0;
  logic [3:0] hit = '0;
  logic fire_ok, run, round_over, fire_ok2, run2, round_over2;
  logic [2:0] ammo, score, ammo2, score2;
  logic [1:0] secs, state, secs2, state2;
  logic [3:0] target_hit, target_hit2;
  int errors = 0;
  int checks = 0;
  always #5 vga_clk = ~vga_clk;
  game_round_controller #(
    .NUM_TARGETS(4), .MAG_DEPTH(4), .SCORE_W(3), .TICKS_PER_SEC(4), .ROUND_SECS(3), .AUTO_START(1)
  ) u_dut (
    .vga_clk(vga_clk), .reset(reset), .start(start), .fire(fire), .reload(reload), .hit(hit),
    .fire_ok(fire_ok), .run(run), .ammo(ammo), .score(score), .secs(secs),
    .target_hit(target_hit), .state(state), .round_over(round_over)
  );
  game_round_controller #(
    .NUM_TARGETS(4), .MAG_DEPTH(4), .SCORE_W(3), .TICKS_PER_SEC(4), .ROUND_SECS(3), .AUTO_START(0)
  ) u_idle (
    .vga_clk(vga_clk), .reset(reset), .start(start2), .fire(1'b0), .reload(1'b0), .hit(4'b0),
    .fire_ok(fire_ok2), .run(run2), .ammo(ammo2), .score(score2), .secs(secs2),
    .target_hit(target_hit2), .state(state2), .round_over(round_over2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask
  initial begin
    int exp_score;
    do_reset();
    check("rst_state", 32'(state), 32'(PLAY));
    check("rst_secs", 32'(secs), 0);
    check("rst_ammo", 32'(ammo), 4);
    check("rst_score", 32'(score), 0);
    check("rst_run", 32'(run), 1);
    check("rst_round_over", 32'(round_over), 0);
    check("rst_target_hit", 32'(target_hit), 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 4) check("secs_1", 32'(secs), 1);
      if (k == 8) check("secs_2", 32'(secs), 2);
      if (k == 11) check("still_play", 32'(state), 32'(PLAY));
    end
    check("over_secs", 32'(secs), 3);
    check("over_state", 32'(state), 32'(OVER));
    check("over_pulse", 32'(round_over), 1);
    check("over_run", 32'(run), 0);
    step(1);
    check("over_pulse_end", 32'(round_over), 0);
    check("over_hold_secs", 32'(secs), 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("restart_state", 32'(state), 32'(PLAY));
    check("restart_secs", 32'(secs), 0);
    for (int p = 0; p < 5; p++) begin
      fire = 1'b1;
      #1;
      check("fire_ok", 32'(fire_ok), (p < 4) ? 1 : 0);
      step(1);
      fire = 1'b0;
      step(1);
      check("ammo_dec", 32'(ammo), (p < 4) ? 3 - p : 0);
    end
    do_reset();
    for (int p = 0; p < 2; p++) begin
      fire = 1'b1;
      step(1);
      fire = 1'b0;
      step(1);
    end
    check("ammo_two", 32'(ammo), 2);
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    reload = 1'b1;
    step(1);
    reload = 1'b0;
    check("reload_wins", 32'(ammo), 4);
    do_reset();
    hit = 4'b0101;
    step(1);
    exp_score = 0;
    for (int r = 0; r < 4; r++) begin
      hit = 4'b0101;
      step(1);
      if (r > 0) check("hit_pulse_clear", 32'(target_hit), 0);
      hit = 4'b0000;
      step(1);
      exp_score = (exp_score + 2 > 7) ? 7 : exp_score + 2;
      check("score_sat", 32'(score), 32'(exp_score));
      check("hit_pulse", 32'(target_hit), 32'b0101);
    end
    do_reset();
    step(10);
    hit = 4'b0010;
    step(1);
    hit = 4'b0000;
    step(1);
    check("expiry_hit_score", 32'(score), 1);
    check("expiry_hit_pulse", 32'(target_hit), 32'b0010);
    check("expiry_state", 32'(state), 32'(OVER));
    hit = 4'b1111;
    fire = 1'b1;
    #1;
    check("over_fire_ok", 32'(fire_ok), 0);
    step(1);
    hit = 4'b0000;
    fire = 1'b0;
    reload = 1'b1;
    step(1);
    reload = 1'b0;
    check("over_score_hold", 32'(score), 1);
    check("over_ammo_hold", 32'(ammo), 4);
    check("over_no_pulse", 32'(target_hit), 0);
    hit = 4'b0001;
    step(1);
    start = 1'b1;
    step(1);
    check("start_state", 32'(state), 32'(PLAY));
    check("start_score_clr", 32'(score), 0);
    check("start_ammo", 32'(ammo), 4);
    start = 1'b0;
    hit = 4'b0000;
    step(1);
    check("post_start_score", 32'(score), 1);
    check("post_start_pulse", 32'(target_hit), 32'b0001);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_ignored", 32'(score), 1);
    do_reset();
    hit = 4'b0111;
    step(1);
    hit = 4'b0000;
    step(1);
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(1);
    step(4);
    check("mid_secs", 32'(secs), 2);
    check("mid_score", 32'(score), 3);
    check("mid_ammo", 32'(ammo), 3);
    do_reset();
    check("mr_secs", 32'(secs), 0);
    check("mr_score", 32'(score), 0);
    check("mr_ammo", 32'(ammo), 4);
    check("mr_state", 32'(state), 32'(PLAY));
    check("idle_state", 32'(state2), 32'(IDLE));
    check("idle_run", 32'(run2), 0);
    step(5);
    check("idle_hold", 32'(state2), 32'(IDLE));
    check("idle_secs", 32'(secs2), 0);
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    check("idle_start", 32'(state2), 32'(PLAY));
    check("idle_start_run", 32'(run2), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_round_controller.md
# game_round_controller

Parametrised round/score controller for the duck-hunt game. It replaces the ad-hoc counter logic in the top level: round timer, magazine/ammo tracking, shot gating, per-target hit scoring and the game state machine. It sits between the comparators, the gun/shot builders and the LED/score display. It runs on the VGA pixel clock and drives a `run` enable that freezes the sprite logic when a round is not active.

## Interface
- `NUM_TARGETS`, 4: number of independent target hit inputs.
- `MAG_DEPTH`, 4: magazine capacity; ammo reload value.
- `SCORE_W`, 8: score counter width.
- `TICKS_PER_SEC`, 24000000: `vga_clk` cycles per round second.
- `ROUND_SECS`, 30: round length in seconds.
- `AUTO_START`, 1: 1 = reset enters PLAY; 0 = reset enters IDLE.

- `vga_clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: level; starts a round from IDLE or OVER.
- `fire`, in, 1: trigger level, debounced externally.
- `reload`, in, 1: reload level.
- `hit`, in, NUM_TARGETS: per-target collision level from the comparators.
- `fire_ok`, out, 1: `fire` gated by state == PLAY and ammo != 0. Combinational from registers and `fire`.
- `run`, out, 1: high in PLAY; enables sprite/shot logic.
- `ammo`, out, $clog2(MAG_DEPTH+1): rounds left.
- `score`, out, SCORE_W: hits this round.
- `secs`, out, $clog2(ROUND_SECS+1): elapsed seconds.
- `target_hit`, out, NUM_TARGETS: one-cycle pulse per scored target.
- `state`, out, 2: IDLE=0, PLAY=1, OVER=2.
- `round_over`, out, 1: one-cycle pulse on entry to OVER.

## Operation
- **Reset:** state = PLAY if AUTO_START else IDLE. score=0, secs=0, prescaler=0, ammo=MAG_DEPTH, target_hit=0, round_over=0. Edge registers `fire_q`=0 and `hit_q`=0.
- **IDLE** → PLAY on `start`=1. Entry clears score, secs and prescaler, and sets ammo=MAG_DEPTH.
- **PLAY:**
  - Prescaler counts 0..TICKS_PER_SEC-1. At the terminal value it wraps to 0 and secs increments.
  - When secs becomes ROUND_SECS, state → OVER on the same edge.
  - `start` is ignored in PLAY.
- **OVER:** counters hold; `run`=0. `start` → PLAY with the same clearing as IDLE entry.
- **Shot accounting:**
  - A shot is the falling edge of `fire` (`fire_q`=1, `fire`=0) in PLAY.
  - A shot decrements ammo if ammo > 0; at 0 ammo is held.
  - `reload`=1 in PLAY sets ammo=MAG_DEPTH. Reload wins over a same-cycle shot.
  - Reload is ignored outside PLAY.
- **Hit scoring:**
  - Target i event = `hit_q[i]` & ~`hit[i]` (collision released) in PLAY.
  - score += popcount(events), saturating at 2^SCORE_W-1.
  - `target_hit[i]` pulses for each event.
- **Edge registers:** `fire_q`/`hit_q` track inputs every cycle in every state, so no phantom edge is seen on entry to PLAY.
- **Simultaneous events:**
  - Timer expiry and a hit in the same cycle: the hit is scored, then the state goes to OVER.
  - Multiple targets released together all count.

## Timing
- All outputs except `fire_ok` are registered.
- An input edge sampled at edge N updates ammo, score and target_hit at edge N+1 (1-cycle latency after the input falls).
- `round_over` is high exactly in the first cycle where state reads OVER.
- `run` follows state with no extra delay.
- Reset asserted mid-round takes effect on the next edge and overrides all other events.

## Structure
- Package `game_pkg`:
  - state localparams IDLE/PLAY/OVER, 2-bit;
  - `popcount` function over NUM_TARGETS;
  - width helper constants derived by $clog2.
- Sub-module `fall_edge_detect #(W)`:
  - registered previous value plus `prev & ~cur` pulse vector;
  - instantiated once for `fire` (W=1) and once for `hit` (W=NUM_TARGETS).
- The remainder is one state register block plus counter blocks, all in the top of this block.

## Test plan
For all scenarios: TICKS_PER_SEC=4, ROUND_SECS=3, MAG_DEPTH=4, SCORE_W=3, AUTO_START=1.

1. **Reset and round length.** Reset then idle 12 cycles: secs steps 0→1→2→3 every 4 cycles, state=OVER at cycle 12, `round_over` high 1 cycle, `run`=0.
2. **Magazine depletion.** Five fire pulses: ammo 4→3→2→1→0→0; `fire_ok`=0 while ammo=0.
3. **Reload priority.** Reload in the same cycle as a fire release with ammo=2 → ammo=4.
4. **Multi-target scoring.** hit=4'b0101 held 2 cycles then 0 → score +2 next edge, `target_hit`=4'b0101 for 1 cycle. Repeat 4 times → score saturates at 7.
5. **Restart and phantom-edge check.** In OVER, assert hit and fire → no score/ammo change. Then `start` while hit held, release hit next cycle → state PLAY, score cleared then =1, ammo=4.
6. **Reset mid-round and IDLE start.** Reset mid-round (secs=2, score=3) → secs=0, score=0, ammo=4, state=PLAY. With AUTO_START=0, reset → IDLE and `run`=0 until `start`.
